// File: rtl/sccb_slave_responder.sv
// SCCB/I2C responder emulating the OV7670 register interface over a 256x8 bank.
// Optional macro SCCB_SLAVE_AUTOINC_EN: reg_ptr auto-increments after every data byte.
module sccb_slave_responder #(
    parameter logic [6:0] C_SLAVE_ADDR = 7'h21,
    parameter int         C_FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_t,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    input  logic [7:0] host_addr,
    output logic [7:0] host_rdata,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_DEV_ADDR  = 4'd1,
        S_DEV_ACK   = 4'd2,
        S_REG_ADDR  = 4'd3,
        S_REG_ACK   = 4'd4,
        S_WR_DATA   = 4'd5,
        S_WR_ACK    = 4'd6,
        S_RD_DATA   = 4'd7,
        S_RD_ACK    = 4'd8,
        S_WAIT_STOP = 4'd9
    } state_t;

    localparam logic [3:0] FLT_LAST = 4'(C_FILTER_LEN - 1);

    // Bit 0 carries SCL, bit 1 carries SDA through sync and filter.
    logic [1:0] sync1, sync2, filt, filt_q;
    logic [3:0] flt_cnt [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= 2'b11;
            sync2      <= 2'b11;
            filt       <= 2'b11;
            filt_q     <= 2'b11;
            flt_cnt[0] <= '0;
            flt_cnt[1] <= '0;
        end else begin
            sync1  <= {sda_i, scl_i};
            sync2  <= sync1;
            filt_q <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == FLT_LAST) begin
                    filt[i]    <= sync2[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + 4'd1;
                end
            end
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  =  filt[0] & ~filt_q[0];
    assign scl_fall  = ~filt[0] &  filt_q[0];
    assign start_det = ~filt[1] &  filt_q[1] & filt[0];
    assign stop_det  =  filt[1] & ~filt_q[1] & filt[0];

    state_t     state;
    logic [7:0] bank [256];
    logic [7:0] reg_ptr, shift, rx_byte, rd_byte, ptr_inc;
    logic [3:0] bit_cnt;
    logic       ack_on, rw_bit;

    assign rx_byte   = {shift[6:0], filt[1]};
    assign rd_byte   = bank[reg_ptr];
    assign sda_o     = 1'b0;
    assign state_dbg = state;

`ifdef SCCB_SLAVE_AUTOINC_EN
    assign ptr_inc = reg_ptr + 8'd1;
`else
    assign ptr_inc = reg_ptr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            sda_t      <= 1'b1;
            wr_strobe  <= 1'b0;
            wr_addr    <= 8'h00;
            wr_data    <= 8'h00;
            busy       <= 1'b0;
            host_rdata <= 8'h00;
            reg_ptr    <= 8'h00;
            shift      <= 8'h00;
            bit_cnt    <= 4'd0;
            ack_on     <= 1'b0;
            rw_bit     <= 1'b0;
            for (int i = 0; i < 256; i++) bank[i] <= 8'h00;
        end else begin
            wr_strobe  <= 1'b0;
            host_rdata <= bank[host_addr];
            if (start_det) begin
                state   <= S_DEV_ADDR;
                bit_cnt <= 4'd0;
                shift   <= 8'h00;
                sda_t   <= 1'b1;
                busy    <= 1'b0;
                ack_on  <= 1'b0;
            end else if (stop_det) begin
                state   <= S_IDLE;
                bit_cnt <= 4'd0;
                sda_t   <= 1'b1;
                busy    <= 1'b0;
                ack_on  <= 1'b0;
            end else begin
                case (state)
                    S_DEV_ADDR: if (scl_rise) begin
                        shift   <= rx_byte;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= 4'd0;
                            if (rx_byte[7:1] == C_SLAVE_ADDR) begin
                                rw_bit <= rx_byte[0];
                                busy   <= 1'b1;
                                state  <= S_DEV_ACK;
                            end else begin
                                state  <= S_WAIT_STOP;
                            end
                        end
                    end
                    // First fall drives ACK low, second fall ends the ACK clock.
                    S_DEV_ACK: if (scl_fall) begin
                        if (!ack_on) begin
                            sda_t  <= 1'b0;
                            ack_on <= 1'b1;
                        end else begin
                            ack_on <= 1'b0;
                            if (rw_bit) begin
                                state   <= S_RD_DATA;
                                sda_t   <= rd_byte[7];
                                shift   <= {rd_byte[6:0], 1'b0};
                                bit_cnt <= 4'd1;
                            end else begin
                                state   <= S_REG_ADDR;
                                sda_t   <= 1'b1;
                                bit_cnt <= 4'd0;
                            end
                        end
                    end
                    S_REG_ADDR: if (scl_rise) begin
                        shift   <= rx_byte;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= 4'd0;
                            reg_ptr <= rx_byte;
                            state   <= S_REG_ACK;
                        end
                    end
                    S_REG_ACK, S_WR_ACK: if (scl_fall) begin
                        if (!ack_on) begin
                            sda_t  <= 1'b0;
                            ack_on <= 1'b1;
                        end else begin
                            ack_on  <= 1'b0;
                            sda_t   <= 1'b1;
                            bit_cnt <= 4'd0;
                            state   <= S_WR_DATA;
                            if (state == S_WR_ACK) reg_ptr <= ptr_inc;
                        end
                    end
                    S_WR_DATA: if (scl_rise) begin
                        shift   <= rx_byte;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt       <= 4'd0;
                            bank[reg_ptr] <= rx_byte;
                            wr_addr       <= reg_ptr;
                            wr_data       <= rx_byte;
                            wr_strobe     <= 1'b1;
                            state         <= S_WR_ACK;
                        end
                    end
                    S_RD_DATA: if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_t   <= 1'b1;
                            bit_cnt <= 4'd0;
                            state   <= S_RD_ACK;
                        end else begin
                            sda_t   <= shift[7];
                            shift   <= {shift[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    // Master ACK continues the read; the next MSB goes out on the following fall.
                    S_RD_ACK: if (scl_rise) begin
                        reg_ptr <= ptr_inc;
                        if (filt[1]) begin
                            state <= S_WAIT_STOP;
                        end else begin
                            shift   <= bank[ptr_inc];
                            bit_cnt <= 4'd0;
                            state   <= S_RD_DATA;
                        end
                    end
                    S_IDLE, S_WAIT_STOP: ;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/sccb_slave_responder.md
Name: sccb_slave_responder

Overview:
- SCCB/I2C-style responder (slave) for the camera control path. It emulates the OV7670 register interface so the SCCB master can be exercised in simulation and in loopback on hardware.
- Oversamples SCL/SDA on the system clock, decodes START/STOP, matches a 7-bit device address, and serves an internal 256x8 register bank.
- Supports write (dev+W, reg addr, data) and read (dev+R, data) transactions, with register-write notification to fabric.

Parameters:
- C_SLAVE_ADDR, 7'h21, 7-bit device address (OV7670: 0x42 write / 0x43 read).
- C_FILTER_LEN, 3, consecutive identical synchronized samples required before a filtered SCL/SDA level changes (1..15).

Ports:
- clk  in  1  system clock; sole clock domain.
- rst  in  1  synchronous reset, active-high.
- scl_i  in  1  SCL from pad (asynchronous).
- sda_i  in  1  SDA from pad (asynchronous).
- sda_o  out  1  SDA output value; constant 0 (open-drain).
- sda_t  out  1  SDA tristate: 1=release (high-Z), 0=drive low.
- wr_strobe  out  1  one-cycle pulse when a bank byte is written over SCCB.
- wr_addr  out  8  register address of the last write.
- wr_data  out  8  data of the last write.
- busy  out  1  high from a matched address ACK until STOP or START.
- host_addr  in  8  fabric read port address.
- host_rdata  out  8  bank[host_addr], registered, 1-cycle latency.

Behaviour:
- Reset (rst=1 at posedge clk, any state): state=IDLE, sda_t=1, wr_strobe=0, wr_addr=0, wr_data=0, busy=0, host_rdata=0, reg_ptr=0, shift/bit counters=0, all bank entries=0x00, filters=1. Reset mid-transaction releases SDA on the next edge with no strobe.
- Input conditioning: 2-flop synchronizer per line, then the C_FILTER_LEN filter. Filtered edges are single-cycle events. Total latency from pad to event: 2+C_FILTER_LEN clk.
- START: filtered SDA fall while filtered SCL=1. STOP: filtered SDA rise while filtered SCL=1. Both are recognised in every state.
  - START/repeated START -> DEV_ADDR, bit count 0, SDA released.
  - STOP -> IDLE, SDA released.
  - reg_ptr is preserved across STOP, so the master can split a read as STOP/START.
- Data sampling: on SCL rise; MSB first. Slave drive changes only on SCL fall.
- States:
  - IDLE: wait for START.
  - DEV_ADDR: shift 8 bits. After the 8th rise, if bits[7:1]==C_SLAVE_ADDR, drive ACK at the next SCL fall, go to DEV_ACK, set busy=1. Otherwise go to WAIT_STOP without ACK.
  - DEV_ACK: hold SDA low through the ACK clock; release on the next SCL fall. R/W=0 -> REG_ADDR. R/W=1 -> RD_DATA: load shift from bank[reg_ptr] and drive the MSB on that same fall.
  - REG_ADDR: shift 8 bits -> reg_ptr; ACK as above -> REG_ACK -> WR_DATA.
  - WR_DATA: shift 8 bits. On the 8th rise: bank[reg_ptr]<=byte, wr_addr<=reg_ptr, wr_data<=byte, pulse wr_strobe one cycle. ACK -> WR_ACK, then reg_ptr<=reg_ptr+1 (8-bit wrap 0xFF->0x00), back to WR_DATA.
  - RD_DATA: drive bit[7-n] (0 -> sda_t=0, 1 -> sda_t=1) on each SCL fall. After 8 bits release SDA -> RD_ACK.
  - RD_ACK: sample master bit on SCL rise.
    - 1 (NACK) -> WAIT_STOP; reg_ptr+1.
    - 0 (ACK) -> reg_ptr+1, load the next byte, continue RD_DATA.
  - WAIT_STOP: SDA released; ignore bits until START/STOP.
- SCL is never stretched; SDA is never driven while SCL is high, except during an ACK/data bit already started.
- Simultaneous bank write and host read of the same address: host_rdata returns the old value.

Optional Feature:
- Macro SCCB_SLAVE_AUTOINC_EN.
  - Defined: reg_ptr increments after every written byte and every read byte, as above (multi-byte bursts).
  - Undefined: reg_ptr changes only in REG_ADDR. Repeated bytes in one write overwrite the same register (one wr_strobe each); repeated reads return the same register. This is the strict OV7670 SCCB behaviour.

Test Plan:
- Write 0x42,0x12,0x80 at 100 kHz -> SDA low in all three ACK slots; wr_strobe once with wr_addr=0x12, wr_data=0x80; host_addr=0x12 gives host_rdata=0x80 next cycle.
- After that write: 0x42,0x12, STOP, START, 0x43, read one byte, NACK -> slave returns 0x80 MSB first; SDA released after NACK; busy=0 after STOP.
- Address 0x60 (dev 0x30) + data -> no ACK on any slot, sda_t=1 throughout, no wr_strobe, bank unchanged.
- 1-clk and (C_FILTER_LEN-1)-clk pulses on SCL/SDA mid-byte -> no bit shift, no START/STOP detected; transfer completes correctly.
- AUTOINC on: write 0x42,0xFF,0x11,0x22 -> bank[0xFF]=0x11, bank[0x00]=0x22, two strobes. AUTOINC off: bank[0xFF]=0x22, bank[0x00] unchanged.
- Assert rst for one cycle during RD_DATA with slave driving 0 -> sda_t=1 the next cycle; state IDLE; a subsequent full write succeeds.
